// File: rtl/shake_coeff_if.sv
// Bus between the SHAKE256 squeeze port, the coefficient unpacker and its consumer.
// Handshake: a beat transfers on a rising edge where valid && ready; a source holds its payload stable while valid && !ready.
interface shake_coeff_if #(
  parameter int COEF_W = 13
);
  logic [63:0]       data_in;
  logic [7:0]        data_in_keep;
  logic              data_in_valid;
  logic              data_in_ready;
  logic              data_in_last;
  logic [COEF_W-1:0] coef_out;
  logic              coef_valid;
  logic              coef_ready;
  logic              coef_last;

  modport master (
    output data_in, data_in_keep, data_in_valid, data_in_last, coef_ready,
    input  data_in_ready, coef_out, coef_valid, coef_last
  );

  modport slave (
    input  data_in, data_in_keep, data_in_valid, data_in_last, coef_ready,
    output data_in_ready, coef_out, coef_valid, coef_last
  );
endinterface

// File: rtl/shake_coeff_unpacker.sv
// Unpacks a keep-qualified 64-bit squeeze stream LSB-first into NUM_COEF coefficients of COEF_W bits.
// A bit buffer refills only when it holds less than one coefficient, so accept and emit never coincide.
module shake_coeff_unpacker #(
  parameter int COEF_W   = 13,
  parameter int NUM_COEF = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  shake_coeff_if.slave bus,
  output logic       done,
  output logic       err_short,
  output logic [1:0] fsm_state
);
  localparam int CNT_W = $clog2(NUM_COEF + 1);
  localparam int BUF_W = 64 + COEF_W - 1;
  localparam logic [6:0]       CW       = 7'(COEF_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COEF - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state, state_n;
  logic [BUF_W-1:0] buffer;
  logic [6:0]       fill;
  logic [CNT_W-1:0] count;
  logic             last_seen;

  logic [3:0]       nbytes;
  logic [63:0]      in_bits;
  logic [BUF_W-1:0] in_shifted;
  logic             accept, emit, short_end, begin_frame;

  // Non-contiguous keep patterns still consume the word but contribute no bytes.
  always_comb begin
    nbytes = 4'd0;
    case (bus.data_in_keep)
      8'h01: nbytes = 4'd1;
      8'h03: nbytes = 4'd2;
      8'h07: nbytes = 4'd3;
      8'h0F: nbytes = 4'd4;
      8'h1F: nbytes = 4'd5;
      8'h3F: nbytes = 4'd6;
      8'h7F: nbytes = 4'd7;
      8'hFF: nbytes = 4'd8;
      default: nbytes = 4'd0;
    endcase
  end

  always_comb begin
    in_bits = '0;
    for (int k = 0; k < 8; k++) begin
      in_bits[8*k +: 8] = (4'(k) < nbytes) ? bus.data_in[8*k +: 8] : 8'h00;
    end
    in_shifted = BUF_W'(in_bits) << fill;
  end

  always_comb begin
    state_n            = state;
    bus.data_in_ready  = 1'b0;
    bus.coef_valid     = 1'b0;
    accept             = 1'b0;
    emit               = 1'b0;
    short_end          = 1'b0;
    begin_frame        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          begin_frame = 1'b1;
          state_n     = S_RUN;
        end
      end
      S_RUN: begin
        bus.data_in_ready = (fill < CW) && !last_seen && !rst;
        bus.coef_valid    = (fill >= CW) && !rst;
        accept            = bus.data_in_ready && bus.data_in_valid;
        emit              = bus.coef_valid && bus.coef_ready;
        if (emit && (count == LAST_IDX)) begin
          state_n = last_seen ? S_DONE : S_FLUSH;
        end else if ((fill < CW) && last_seen) begin
          short_end = 1'b1;
          state_n   = S_DONE;
        end
      end
      S_FLUSH: begin
        bus.data_in_ready = !rst;
        accept            = bus.data_in_ready && bus.data_in_valid;
        if (accept && bus.data_in_last) state_n = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          begin_frame = 1'b1;
          state_n     = S_RUN;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      buffer    <= '0;
      fill      <= '0;
      count     <= '0;
      last_seen <= 1'b0;
      err_short <= 1'b0;
    end else begin
      state <= state_n;
      if (begin_frame) begin
        buffer    <= '0;
        fill      <= '0;
        count     <= '0;
        last_seen <= 1'b0;
        err_short <= 1'b0;
      end else if (state == S_RUN) begin
        if (accept) begin
          buffer    <= buffer | in_shifted;
          fill      <= fill + {nbytes, 3'b000};
          last_seen <= bus.data_in_last;
        end else if (emit) begin
          count <= count + CNT_W'(1);
          // Leaving S_RUN drops whatever surplus bits remain.
          if (state_n != S_RUN) begin
            buffer <= '0;
            fill   <= '0;
          end else begin
            buffer <= buffer >> COEF_W;
            fill   <= fill - CW;
          end
        end else if (short_end) begin
          err_short <= 1'b1;
          buffer    <= '0;
          fill      <= '0;
        end
      end
    end
  end

  assign bus.coef_out  = buffer[COEF_W-1:0];
  assign bus.coef_last = bus.coef_valid && (count == LAST_IDX);
  assign done          = (state == S_DONE);
  assign fsm_state     = state;
endmodule
